next_pc_ctrl: RTL and testbench

NEXT_PC_CTRL -- requirements
Module: next_pc_ctrl

---
 rtl/next_pc_ctrl.sv | 150 +++++++++++++++
 tb/tb_next_pc_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_ctrl.sv
// Next-PC selection with a BOOT/RUN/HOLD controller and a one-entry pending-redirect buffer.
// Exception entry/return support is compiled in only when NEXT_PC_CTRL_EXC_EN is defined.
module next_pc_ctrl #(
  parameter logic [29:0] RESET_PC = 30'h0C00,
  parameter logic [29:0] EXC_VEC  = 30'h0C60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] pc_cur,
  input  logic        stall,
  input  logic        br_req,
  input  logic [29:0] br_target,
  input  logic        jmp_req,
  input  logic [29:0] jmp_target,
  input  logic        exc_req,
  input  logic        eret_req,
  output logic [29:0] next_pc,
  output logic        pc_en,
  output logic        flush,
  output logic        pend_vld,
  output logic [29:0] epc_out
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Numeric order of the classes is the redirect priority.
  typedef enum logic [2:0] {
    CLS_SEQ  = 3'd0,
    CLS_BR   = 3'd1,
    CLS_JMP  = 3'd2,
    CLS_ERET = 3'd3,
    CLS_EXC  = 3'd4
  } cls_t;

  state_t      state, state_nxt;
  cls_t        req_cls, pend_cls;
  logic [29:0] req_tgt, pend_tgt, seq_pc;
  logic        exc_act, eret_act;
  logic        pend_wr, pend_clr, epc_wr;

`ifdef NEXT_PC_CTRL_EXC_EN
  assign exc_act  = exc_req;
  assign eret_act = eret_req;
`else
  assign exc_act  = 1'b0;
  assign eret_act = 1'b0;
  wire unused_exc = &{1'b0, exc_req, eret_req};
`endif

  assign seq_pc = pc_cur + 30'd1;

  // Highest-priority request presented this cycle.
  always_comb begin
    req_cls = CLS_SEQ;
    req_tgt = seq_pc;
    if (exc_act) begin
      req_cls = CLS_EXC;
      req_tgt = EXC_VEC;
    end else if (eret_act) begin
      req_cls = CLS_ERET;
      req_tgt = epc_out;
    end else if (jmp_req) begin
      req_cls = CLS_JMP;
      req_tgt = jmp_target;
    end else if (br_req) begin
      req_cls = CLS_BR;
      req_tgt = br_target;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    next_pc   = seq_pc;
    pc_en     = 1'b0;
    flush     = 1'b0;
    pend_wr   = 1'b0;
    pend_clr  = 1'b0;
    epc_wr    = 1'b0;
    unique case (state)
      BOOT: begin
        next_pc   = RESET_PC;
        state_nxt = RUN;
      end
      RUN, HOLD: begin
        if (stall) begin
          next_pc = req_tgt;
          if (req_cls != CLS_SEQ) begin
            pend_wr   = !pend_vld || (req_cls >= pend_cls);
            epc_wr    = exc_act;
            state_nxt = HOLD;
          end
        end else begin
          state_nxt = RUN;
          pc_en     = 1'b1;
          epc_wr    = exc_act;
          pend_clr  = pend_vld;
          if (pend_vld && !(req_cls > pend_cls)) begin
            next_pc = pend_tgt;
            flush   = 1'b1;
          end else begin
            next_pc = req_tgt;
            flush   = (req_cls != CLS_SEQ);
          end
        end
      end
      default: state_nxt = BOOT;
    endcase
    // Reset is synchronous, but outputs show BOOT values for the whole time it is held.
    if (!rst_n) begin
      state_nxt = BOOT;
      next_pc   = RESET_PC;
      pc_en     = 1'b0;
      flush     = 1'b0;
      pend_wr   = 1'b0;
      pend_clr  = 1'b0;
      epc_wr    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      pend_vld <= 1'b0;
      pend_cls <= CLS_SEQ;
      epc_out  <= '0;
    end else begin
      state <= state_nxt;
      if (pend_wr) begin
        pend_vld <= 1'b1;
        pend_cls <= req_cls;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
        pend_cls <= CLS_SEQ;
      end
      if (epc_wr) epc_out <= pc_cur;
    end
  end

  // NOTE: the target is pure data qualified by pend_vld, so it deliberately has no reset.
  always_ff @(posedge clk) begin
    if (pend_wr) pend_tgt <= req_tgt;
  end

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Directed self-checking bench for next_pc_ctrl; exception checks follow NEXT_PC_CTRL_EXC_EN.
module tb_next_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] pc_cur;
  logic        stall;
  logic        br_req;
  logic [29:0] br_target;
  logic        jmp_req;
  logic [29:0] jmp_target;
  logic        exc_req;
  logic        eret_req;
  logic [29:0] next_pc;
  logic        pc_en;
  logic        flush;
  logic        pend_vld;
  logic [29:0] epc_out;

  int checks   = 0;
  int failures = 0;

  next_pc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_cur    (pc_cur),
    .stall     (stall),
    .br_req    (br_req),
    .br_target (br_target),
    .jmp_req   (jmp_req),
    .jmp_target(jmp_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .next_pc   (next_pc),
    .pc_en     (pc_en),
    .flush     (flush),
    .pend_vld  (pend_vld),
    .epc_out   (epc_out)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    stall      = 1'b0;
    br_req     = 1'b0;
    br_target  = '0;
    jmp_req    = 1'b0;
    jmp_target = '0;
    exc_req    = 1'b0;
    eret_req   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    pc_cur = 30'h0C10;
    clear_reqs();
    @(negedge clk);
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL rst_pc_en got=%b exp=0", pc_en); end
    checks++; if (next_pc !== 30'h0C00) begin failures++; $display("FAIL rst_next_pc got=%h exp=0c00", next_pc); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", flush); end
    tick();
    tick();
    checks++; if (pend_vld !== 1'b0) begin failures++; $display("FAIL rst_pend_vld got=%b exp=0", pend_vld); end
    checks++; if (epc_out !== 30'h0) begin failures++; $display("FAIL rst_epc got=%h exp=0", epc_out); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL boot_pc_en got=%b exp=0", pc_en); end
    checks++; if (next_pc !== 30'h0C00) begin failures++; $display("FAIL boot_next_pc got=%h exp=0c00", next_pc); end
    tick();
    @(negedge clk);
    checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL run_pc_en got=%b exp=1", pc_en); end
    checks++; if (next_pc !== 30'h0C11) begin failures++; $display("FAIL run_seq got=%h exp=0c11", next_pc); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL run_flush got=%b exp=0", flush); end
    tick();
  endtask

  task automatic test_priority();
    pc_cur = 30'h0C10;
    br_req = 1'b1; br_target = 30'h0D00;
    jmp_req = 1'b1; jmp_target = 30'h0E00;
    @(negedge clk);
    checks++; if (next_pc !== 30'h0E00) begin failures++; $display("FAIL prio_jmp got=%h exp=0e00", next_pc); end
    checks++; if (flush !== 1'b1 || pc_en !== 1'b1) begin failures++; $display("FAIL prio_flags got=%b%b exp=11", flush, pc_en); end
    tick();
    jmp_req = 1'b0;
    @(negedge clk);
    checks++; if (next_pc !== 30'h0D00 || flush !== 1'b1) begin failures++; $display("FAIL prio_br got=%h/%b exp=0d00/1", next_pc, flush); end
    tick();
    clear_reqs();
  endtask

  task automatic test_stall_buffer();
    pc_cur = 30'h0C20;
    stall  = 1'b1;
    br_req = 1'b1; br_target = 30'h0D00;
    @(negedge clk);
    checks++; if (pc_en !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL stall_flags got=%b%b exp=00", pc_en, flush); end
    tick();
    br_req = 1'b0; br_target = '0;
    @(negedge clk);
    checks++; if (pend_vld !== 1'b1) begin failures++; $display("FAIL stall_pend got=%b exp=1", pend_vld); end
    tick();
    @(negedge clk);
    checks++; if (pend_vld !== 1'b1 || pc_en !== 1'b0) begin failures++; $display("FAIL stall_hold got=%b%b exp=10", pend_vld, pc_en); end
    tick();
    stall = 1'b0;
    @(negedge clk);
    checks++; if (next_pc !== 30'h0D00) begin failures++; $display("FAIL release_tgt got=%h exp=0d00", next_pc); end
    checks++; if (pc_en !== 1'b1 || flush !== 1'b1) begin failures++; $display("FAIL release_flags got=%b%b exp=11", pc_en, flush); end
    tick();
    pc_cur = 30'h0D00;
    @(negedge clk);
    checks++; if (pend_vld !== 1'b0) begin failures++; $display("FAIL release_clr got=%b exp=0", pend_vld); end
    checks++; if (next_pc !== 30'h0D01 || flush !== 1'b0) begin failures++; $display("FAIL after_release got=%h/%b exp=0d01/0", next_pc, flush); end
    tick();
  endtask

  task automatic test_override();
    // Pending br overwritten by a later jmp during the same stall.
    pc_cur = 30'h0C30;
    stall = 1'b1; br_req = 1'b1; br_target = 30'h0D00;
    tick();
    br_req = 1'b0; jmp_req = 1'b1; jmp_target = 30'h0E00;
    tick();
    clear_reqs();
    @(negedge clk);
    checks++; if (next_pc !== 30'h0E00) begin failures++; $display("FAIL ovr_jmp got=%h exp=0e00", next_pc); end
    tick();
    // Pending jmp beats a br arriving on the release cycle.
    stall = 1'b1; jmp_req = 1'b1; jmp_target = 30'h0E40;
    tick();
    clear_reqs();
    br_req = 1'b1; br_target = 30'h0D40;
    @(negedge clk);
    checks++; if (next_pc !== 30'h0E40 || flush !== 1'b1) begin failures++; $display("FAIL ovr_keep got=%h/%b exp=0e40/1", next_pc, flush); end
    tick();
    clear_reqs();
    // A lower class arriving later in the stall must not replace a pending jmp.
    stall = 1'b1; jmp_req = 1'b1; jmp_target = 30'h0E80;
    tick();
    jmp_req = 1'b0; br_req = 1'b1; br_target = 30'h0D80;
    tick();
    clear_reqs();
    @(negedge clk);
    checks++; if (next_pc !== 30'h0E80) begin failures++; $display("FAIL ovr_lower got=%h exp=0e80", next_pc); end
    tick();
    // A strictly higher new request wins over the pending br on release.
    stall = 1'b1; br_req = 1'b1; br_target = 30'h0DC0;
    tick();
    clear_reqs();
    jmp_req = 1'b1; jmp_target = 30'h0EC0;
    @(negedge clk);
    checks++; if (next_pc !== 30'h0EC0) begin failures++; $display("FAIL ovr_higher got=%h exp=0ec0", next_pc); end
    tick();
    clear_reqs();
  endtask

  task automatic test_wrap();
    pc_cur = 30'h3FFF_FFFF;
    @(negedge clk);
    checks++; if (next_pc !== 30'h0 || pc_en !== 1'b1) begin failures++; $display("FAIL wrap got=%h/%b exp=0/1", next_pc, pc_en); end
    tick();
  endtask

  task automatic test_reset_hold();
    pc_cur = 30'h0C40;
    stall = 1'b1; br_req = 1'b1; br_target = 30'h0D00;
    tick();
    clear_reqs();
    stall = 1'b1;
    @(negedge clk);
    checks++; if (pend_vld !== 1'b1) begin failures++; $display("FAIL rh_pend got=%b exp=1", pend_vld); end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (next_pc !== 30'h0C00 || pc_en !== 1'b0) begin failures++; $display("FAIL rh_outs got=%h/%b exp=0c00/0", next_pc, pc_en); end
    tick();
    checks++; if (pend_vld !== 1'b0) begin failures++; $display("FAIL rh_clr got=%b exp=0", pend_vld); end
    rst_n = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    checks++; if (pc_en !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL rh_boot got=%b%b exp=00", pc_en, flush); end
    tick();
    @(negedge clk);
    checks++; if (next_pc !== 30'h0C41 || flush !== 1'b0) begin failures++; $display("FAIL rh_noredir got=%h/%b exp=0c41/0", next_pc, flush); end
    tick();
  endtask

  task automatic test_exc();
    pc_cur = 30'h0C20;
    exc_req = 1'b1;
    jmp_req = 1'b1; jmp_target = 30'h0E00;
    @(negedge clk);
`ifdef NEXT_PC_CTRL_EXC_EN
    checks++; if (next_pc !== 30'h0C60 || flush !== 1'b1) begin failures++; $display("FAIL exc_tgt got=%h/%b exp=0c60/1", next_pc, flush); end
`else
    checks++; if (next_pc !== 30'h0E00) begin failures++; $display("FAIL exc_off got=%h exp=0e00", next_pc); end
`endif
    tick();
    clear_reqs();
    pc_cur = 30'h0C60;
`ifdef NEXT_PC_CTRL_EXC_EN
    checks++; if (epc_out !== 30'h0C20) begin failures++; $display("FAIL exc_epc got=%h exp=0c20", epc_out); end
`else
    checks++; if (epc_out !== 30'h0) begin failures++; $display("FAIL exc_epc_off got=%h exp=0", epc_out); end
`endif
    tick();
    pc_cur = 30'h0C61;
    eret_req = 1'b1;
    @(negedge clk);
`ifdef NEXT_PC_CTRL_EXC_EN
    checks++; if (next_pc !== 30'h0C20 || flush !== 1'b1) begin failures++; $display("FAIL eret_tgt got=%h/%b exp=0c20/1", next_pc, flush); end
`else
    checks++; if (next_pc !== 30'h0C62 || flush !== 1'b0) begin failures++; $display("FAIL eret_off got=%h/%b exp=0c62/0", next_pc, flush); end
`endif
    tick();
    clear_reqs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_stall_buffer();
    test_override();
    test_wrap();
    test_reset_hold();
    test_exc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
